// File: rtl/rxepktgate_pkg.sv
// Shared ethernet receive definitions: minimum frame length and the
// state encodings of the rx packet gate's write and read FSMs.
package rxepktgate_pkg;

    localparam int ETH_MINLEN = 64;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_RECV = 2'd1;
    localparam logic [1:0] W_END  = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_LOAD = 2'd1;
    localparam logic [1:0] R_SEND = 2'd2;

endpackage

// File: rtl/rxepktlenq.sv
// Committed-packet length queue: small synchronous FIFO.
// Ports: i_push/i_data write, i_pop/o_data read (head shown
// combinationally), o_full/o_empty status. Async active-low reset.
module rxepktlenq #(
    parameter int LGPKT = 2,
    parameter int DW    = 12
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [LGPKT-1:0] ONE = LGPKT'(1);

    logic [DW-1:0]    mem [2**LGPKT];
    logic [LGPKT-1:0] wp;
    logic [LGPKT-1:0] rp;

    // One slot is kept open so full and empty stay distinct:
    // the queue holds 2^LGPKT-1 lengths.
    assign o_empty = (wp == rp);
    assign o_full  = ((wp + ONE) == rp);
    assign o_data  = mem[rp];

    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            mem[wp] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (i_push && !o_full) begin
                wp <= wp + ONE;
            end
            if (i_pop && !o_empty) begin
                rp <= rp + ONE;
            end
        end
    end

endmodule

// File: rtl/rxepktgate.sv
// Rx packet gate: buffers each packet, commits or rolls it back on the
// checker verdict, and replays committed packets as a valid/ready stream.
// Ports: i_clk, i_reset_n (async low); i_v/i_d/i_err/i_en rx side;
// o_rx_valid/o_rx_data/o_rx_last/i_rx_ready out; o_npkts/o_nerr/o_novfl.
module rxepktgate
    import rxepktgate_pkg::*;
#(
    parameter int LGBUF  = 11,
    parameter int LGPKT  = 2,
    parameter int MINLEN = ETH_MINLEN
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_v,
    input  logic [7:0]  i_d,
    input  logic        i_err,
    output logic        o_rx_valid,
    output logic [7:0]  o_rx_data,
    output logic        o_rx_last,
    input  logic        i_rx_ready,
    output logic [15:0] o_npkts,
    output logic [15:0] o_nerr,
    output logic [15:0] o_novfl
);

    localparam int PW = LGBUF + 1;
    localparam logic [PW-1:0]    P1    = PW'(1);
    localparam logic [PW-1:0]    BUFSZ = PW'(2**LGBUF);
    localparam logic [PW-1:0]    MINL  = PW'(MINLEN);
    localparam logic [LGBUF-1:0] A1    = LGBUF'(1);

    logic [7:0]       mem [2**LGBUF];
    logic [1:0]       wstate, wnext;
    logic [1:0]       rstate, rnext;
    logic [PW-1:0]    wr_ptr, wr_commit, rd_ptr;
    logic [PW-1:0]    len, len_inc, rcnt, q_len, used;
    logic             ovfl, buf_full, len_ovf;
    logic             pkt_start, pkt_end, bad_ovfl, bad_err;
    logic             commit, rollback, wr_en;
    logic             q_full, q_empty;
    logic             accept, is_last, pop, rd_en;
    logic [LGBUF-1:0] ra;

    // Occupancy against the current rd_ptr; bytes freed this cycle
    // are not counted, so the full test is one byte conservative.
    assign used     = wr_ptr - rd_ptr;
    assign buf_full = (used == BUFSZ);
    assign len_inc  = (len == '1) ? len : len + P1;
    assign len_ovf  = len_inc[LGBUF];

    rxepktlenq #(
        .LGPKT (LGPKT),
        .DW    (PW)
    ) u_lenq (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (commit),
        .i_data    (len),
        .i_pop     (pop),
        .o_data    (q_len),
        .o_full    (q_full),
        .o_empty   (q_empty)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) wstate <= W_IDLE;
        else            wstate <= wnext;
    end

    always_comb begin
        wnext = wstate;
        unique case (wstate)
            W_IDLE:  if (i_v) wnext = W_RECV;
            W_RECV:  if (!i_v) wnext = W_END;
            W_END:   wnext = i_v ? W_RECV : W_IDLE;
            default: wnext = W_IDLE;
        endcase
    end

    // The verdict is taken on the first i_v=0 cycle, while the
    // checkers still hold their error; W_END is the settle cycle
    // in which a new packet may already start at the new pointer.
    always_comb begin
        pkt_start = i_v && (wstate != W_RECV);
        pkt_end   = (wstate == W_RECV) && !i_v;
        bad_ovfl  = ovfl || q_full;
        bad_err   = (i_en && i_err) || (len < MINL);
        commit    = pkt_end && !bad_ovfl && !bad_err;
        rollback  = pkt_end && !commit;
        wr_en     = i_v && !buf_full && (pkt_start || !ovfl);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
            len       <= '0;
            ovfl      <= 1'b0;
            o_npkts   <= '0;
            o_nerr    <= '0;
            o_novfl   <= '0;
        end else begin
            if (rollback)   wr_ptr <= wr_commit;
            else if (wr_en) wr_ptr <= wr_ptr + P1;
            if (pkt_start) begin
                len  <= P1;
                ovfl <= buf_full;
            end else if (i_v) begin
                len <= len_inc;
                if (buf_full || len_ovf) ovfl <= 1'b1;
            end
            if (commit) begin
                wr_commit <= wr_ptr;
                o_npkts   <= o_npkts + 16'd1;
            end
            if (rollback && bad_ovfl)  o_novfl <= o_novfl + 16'd1;
            else if (rollback)         o_nerr  <= o_nerr + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[LGBUF-1:0]] <= i_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rstate <= R_IDLE;
        else            rstate <= rnext;
    end

    always_comb begin
        rnext = rstate;
        unique case (rstate)
            R_IDLE:  if (!q_empty) rnext = R_LOAD;
            R_LOAD:  rnext = R_SEND;
            R_SEND:  if (accept && is_last && q_empty) rnext = R_IDLE;
            default: rnext = R_IDLE;
        endcase
    end

    // The output byte register is the RAM read register: it loads
    // the head byte in R_LOAD and prefetches the next on accept.
    always_comb begin
        accept     = (rstate == R_SEND) && i_rx_ready;
        is_last    = (rcnt == P1);
        pop        = !q_empty && ((rstate == R_IDLE) || (accept && is_last));
        rd_en      = (rstate == R_LOAD) || accept;
        ra         = (rstate == R_LOAD) ? rd_ptr[LGBUF-1:0]
                                        : rd_ptr[LGBUF-1:0] + A1;
        o_rx_valid = (rstate == R_SEND);
        o_rx_last  = o_rx_valid && is_last;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr    <= '0;
            rcnt      <= '0;
            o_rx_data <= '0;
        end else begin
            if (accept) rd_ptr <= rd_ptr + P1;
            if (pop)         rcnt <= q_len;
            else if (accept) rcnt <= rcnt - P1;
            if (rd_en) o_rx_data <= mem[ra];
        end
    end

endmodule

// File: tb/tb_rxepktgate.sv
// Self-checking bench for rxepktgate: vector table, corner sequences,
// and randomized packets against a packet-level scoreboard.
module tb_rxepktgate;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        int len;
        int err_at;
        bit en;
        bit dlv;
        int dp;
        int de;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        v = 1'b0;
    logic        v7 = 1'b0;
    logic [7:0]  d = '0;
    logic        err = 1'b0;
    logic        rdy = 1'b0;
    logic        rdy7 = 1'b0;
    logic        val, lst, val7, lst7;
    logic [7:0]  dat, dat7;
    logic [15:0] np, ne, no, np7, ne7, no7;

    int    checks = 0;
    int    fails = 0;
    int    rmode = 0;
    int    exp_np = 0;
    int    exp_ne = 0;
    int    exp_no = 0;
    int    n7 = 0;
    int    l7 = 0;
    beat_t expq[$];
    beat_t exp7[$];
    vec_t  tbl[9];

    rxepktgate dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_en       (en),
        .i_v        (v),
        .i_d        (d),
        .i_err      (err),
        .o_rx_valid (val),
        .o_rx_data  (dat),
        .o_rx_last  (lst),
        .i_rx_ready (rdy),
        .o_npkts    (np),
        .o_nerr     (ne),
        .o_novfl    (no)
    );

    rxepktgate #(.LGBUF(7)) dut7 (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_en       (en),
        .i_v        (v7),
        .i_d        (d),
        .i_err      (err),
        .o_rx_valid (val7),
        .o_rx_data  (dat7),
        .o_rx_last  (lst7),
        .i_rx_ready (rdy7),
        .o_npkts    (np7),
        .o_nerr     (ne7),
        .o_novfl    (no7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom);
                default: rdy = 1'b0;
            endcase
        end
    end

    initial begin
        beat_t b;
        logic  pv, prdy, pl;
        logic [7:0] pd;
        pv = 1'b0; prdy = 1'b0; pl = 1'b0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (val && rdy) begin
                    chk("byte_expected", 32'(expq.size() > 0), 32'(1));
                    if (expq.size() > 0) begin
                        b = expq.pop_front();
                        chk("data", 32'(dat), 32'(b.d));
                        chk("last", 32'(lst), 32'(b.l));
                    end
                end
                if (pv && !prdy) begin
                    chk("stall_valid", 32'(val), 32'(1));
                    chk("stall_data", 32'(dat), 32'(pd));
                    chk("stall_last", 32'(lst), 32'(pl));
                end
                pv = val; prdy = rdy; pd = dat; pl = lst;
                if (val7 && rdy7) begin
                    n7++;
                    if (lst7) l7++;
                    chk("byte7_expected", 32'(exp7.size() > 0), 32'(1));
                    if (exp7.size() > 0) begin
                        b = exp7.pop_front();
                        chk("data7", 32'(dat7), 32'(b.d));
                        chk("last7", 32'(lst7), 32'(b.l));
                    end
                end
            end else begin
                pv = 1'b0;
            end
        end
    end

    // err follows the sticky checker model; it is still held in the
    // first i_v=0 cycle, which is when the gate samples it.
    task automatic send(input bit sel, input int len, input int err_at,
                        input bit dlv);
        logic [7:0] bytes[$];
        beat_t b;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            if (sel) v7 = 1'b1;
            else     v = 1'b1;
            d = 8'($urandom);
            err = (err_at != 0) && (i + 1 >= err_at);
            bytes.push_back(d);
        end
        @(posedge clk);
        #1;
        v = 1'b0;
        v7 = 1'b0;
        err = (err_at != 0) && (len + 1 >= err_at);
        if (dlv) begin
            for (int i = 0; i < len; i++) begin
                b.d = bytes[i];
                b.l = (i == len - 1);
                if (sel) exp7.push_back(b);
                else     expq.push_back(b);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            v = 1'b0;
            v7 = 1'b0;
            err = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((expq.size() != 0 || val) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(expq.size() == 0 && !val), 32'(1));
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_npkts"}, 32'(np), 32'(exp_np));
        chk({nm, "_nerr"}, 32'(ne), 32'(exp_ne));
        chk({nm, "_novfl"}, 32'(no), 32'(exp_no));
    endtask

    task automatic hit_reset(input string nm);
        rst_n = 1'b0;
        v = 1'b0;
        err = 1'b0;
        #1;
        expq.delete();
        exp_np = 0;
        exp_ne = 0;
        exp_no = 0;
        chk({nm, "_valid"}, 32'(val), 32'(0));
        chk_cnt(nm);
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int k;
        tbl[0] = '{64, 0, 1'b1, 1'b1, 1, 0};
        tbl[1] = '{100, 30, 1'b1, 1'b0, 0, 1};
        tbl[2] = '{100, 30, 1'b0, 1'b1, 1, 0};
        tbl[3] = '{40, 0, 1'b1, 1'b0, 0, 1};
        tbl[4] = '{64, 0, 1'b1, 1'b1, 1, 0};
        tbl[5] = '{63, 0, 1'b1, 1'b0, 0, 1};
        tbl[6] = '{65, 65, 1'b1, 1'b0, 0, 1};
        tbl[7] = '{70, 71, 1'b1, 1'b0, 0, 1};
        tbl[8] = '{200, 0, 1'b1, 1'b1, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(val), 32'(0));
        chk("rst_last", 32'(lst), 32'(0));
        chk("rst_data", 32'(dat), 32'(0));
        chk_cnt("rst");
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            rmode = (i >= 5) ? 1 : 0;
            en = tbl[i].en;
            send(1'b0, tbl[i].len, tbl[i].err_at, tbl[i].dlv);
            idle(2);
            drain($sformatf("vec%0d_drain", i));
            exp_np += tbl[i].dp;
            exp_ne += tbl[i].de;
            chk_cnt($sformatf("vec%0d", i));
        end
        en = 1'b1;

        rmode = 2;
        idle(2);
        for (int i = 0; i < 5; i++) send(1'b0, 64, 0, i < 4);
        idle(2);
        exp_np += 4;
        exp_no += 1;
        chk_cnt("b2b");
        rmode = 0;
        drain("b2b_drain");

        rdy7 = 1'b0;
        send(1'b1, 64, 0, 1'b1);
        idle(1);
        send(1'b1, 64, 0, 1'b1);
        idle(1);
        send(1'b1, 64, 0, 1'b0);
        idle(2);
        chk("small_npkts", 32'(np7), 32'(2));
        chk("small_novfl", 32'(no7), 32'(1));
        chk("small_nerr", 32'(ne7), 32'(0));
        rdy7 = 1'b1;
        k = 0;
        while ((exp7.size() != 0 || val7) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        idle(5);
        chk("small_bytes", 32'(n7), 32'(128));
        chk("small_lasts", 32'(l7), 32'(2));

        rmode = 1;
        send(1'b0, 200, 0, 1'b1);
        k = 0;
        while (expq.size() > 150 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("readout_started", 32'(expq.size() <= 150), 32'(1));
        @(posedge clk);
        #1;
        hit_reset("rst_readout");

        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            v = 1'b1;
            d = 8'($urandom);
        end
        @(posedge clk);
        #1;
        hit_reset("rst_midpkt");
        idle(2);
        send(1'b0, 64, 0, 1'b1);
        idle(2);
        drain("post_rst_drain");
        exp_np += 1;
        chk_cnt("post_rst");

        rmode = 1;
        for (int i = 0; i < 20; i++) begin
            int  len, ea;
            bit  dlv;
            len = $urandom_range(200, 40);
            ea = ($urandom_range(2, 0) == 0) ? $urandom_range(len + 1, 1) : 0;
            en = 1'($urandom);
            dlv = !(en && ea != 0) && (len >= 64);
            send(1'b0, len, ea, dlv);
            idle(2);
            drain($sformatf("rnd%0d_drain", i));
            if (dlv) exp_np++;
            else     exp_ne++;
        end
        chk_cnt("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
